// File: rtl/uart_pkg.sv
// Shared definitions for the 32-bit UART link (receiver and transmitter).
// Holds the receiver state encoding, link constants, parity encoding and
// small bit-level helper functions.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int BITS_PER_WORD        = 32;
  localparam int CLKS_PER_BIT_DEFAULT = 10417;

  // parity_type encoding, shared with the transmitter
  localparam logic PARITY_EVEN = 1'b1;
  localparam logic PARITY_ODD  = 1'b0;

  // Parity bit the transmitter should have sent for this word
  function automatic logic expected_parity(input logic [BITS_PER_WORD-1:0] word,
                                           input logic                     ptype);
    logic p;
    p = ^word;
    if (ptype == PARITY_EVEN) begin
      return p;
    end else begin
      return ~p;
    end
  endfunction

  // 2-of-3 vote
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Front end of the UART receiver: 2-flop synchronizer for the asynchronous
// rx pin, falling-edge detect, and the per-bit sample value.
// Build option: UART_RX_MAJORITY_EN -- sample becomes a 2-of-3 vote over the
// last three synchronized values, so the FSM must decide one cycle after the
// nominal sample point to centre the vote window on it.
import uart_pkg::*;

module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic fall,
  output logic sample
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
`ifdef UART_RX_MAJORITY_EN
  logic prev2_q, prev2_d;
`endif

  // Next-state: shift the pin through the synchronizer and history taps
  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
`ifdef UART_RX_MAJORITY_EN
    prev2_d = prev_q;
`endif
  end

  // Synchronizer and history flops; idle-high reset value avoids a false edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      prev2_q <= 1'b1;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
`ifdef UART_RX_MAJORITY_EN
      prev2_q <= prev2_d;
`endif
    end
  end

  assign fall = prev_q & ~sync2_q;

`ifdef UART_RX_MAJORITY_EN
  assign sample = majority3(prev2_q, prev_q, sync2_q);
`else
  assign sample = sync2_q;
`endif

endmodule

// File: rtl/uart_receiver.sv
// UART receiver for the 32-bit link: start, 32 data bits LSB first, parity,
// stop. Mid-bit sampling driven by a per-bit counter; the completed word is
// presented with a one-cycle valid pulse plus parity/framing error flags.
// Build option: UART_RX_MAJORITY_EN -- 2-of-3 majority sampling; all decision
// points move one cycle later (done once, at start-bit validation, since the
// counter is cleared at every decision).
import uart_pkg::*;

module uart_receiver #(
  parameter int CLKS_PER_BIT  = CLKS_PER_BIT_DEFAULT,
  parameter int BITS_PER_WORD = uart_pkg::BITS_PER_WORD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx,
  input  logic                     parity_type,
  output logic [BITS_PER_WORD-1:0] data,
  output logic                     valid,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(BITS_PER_WORD);
  localparam int HALF  = CLKS_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int VOTE_DELAY = 1;
`else
  localparam int VOTE_DELAY = 0;
`endif

  localparam logic [CNT_W-1:0] START_PT = CNT_W'(HALF - 1 + VOTE_DELAY);
  localparam logic [CNT_W-1:0] BIT_PT   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BITS_PER_WORD - 1);

  logic fall_s;
  logic sample_s;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx     (rx),
    .fall   (fall_s),
    .sample (sample_s)
  );

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q,   cnt_d;
  logic [IDX_W-1:0]         idx_q,   idx_d;
  logic [BITS_PER_WORD-1:0] word_q,  word_d;
  logic                     ptype_q, ptype_d;
  logic                     par_q,   par_d;
  logic [BITS_PER_WORD-1:0] data_q,  data_d;
  logic                     valid_q, valid_d;
  logic                     perr_q,  perr_d;
  logic                     ferr_q,  ferr_d;
  logic                     busy_q,  busy_d;

  // Frame FSM next-state: bit timing, reassembly and result reporting
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    word_d  = word_q;
    ptype_d = ptype_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    busy_d  = busy_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end

      START: begin
        if (cnt_q == START_PT) begin
          cnt_d = '0;
          if (!sample_s) begin
            ptype_d = parity_type;
            busy_d  = 1'b1;
            idx_d   = '0;
            word_d  = '0;
            state_d = DATA;
          end else begin
            // line went back high: glitch, not a start bit
            state_d = IDLE;
          end
        end else begin
          state_d = START;
        end
      end

      DATA: begin
        if (cnt_q == BIT_PT) begin
          cnt_d         = '0;
          word_d[idx_q] = sample_s;
          if (idx_q == LAST_IDX) begin
            state_d = PARITY;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = DATA;
        end
      end

      PARITY: begin
        if (cnt_q == BIT_PT) begin
          cnt_d   = '0;
          par_d   = sample_s;
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end

      STOP: begin
        if (cnt_q == BIT_PT) begin
          cnt_d   = '0;
          data_d  = word_q;
          valid_d = 1'b1;
          perr_d  = (par_q != expected_parity(word_q, ptype_q));
          ferr_d  = ~sample_s;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end

      default: begin
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous reset discards any partial frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      ptype_q <= PARITY_EVEN;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      ptype_q <= ptype_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;

endmodule
